// File: rtl/mem_wait_ctrl.sv
// Memory-access stage responder: turns an RV32 load/store into a word-aligned
// bus transaction and holds memWait to the stage clock until the bus finishes.
module mem_wait_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLK_MA,
  input  logic        rwmem,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        memWait,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  // access attributes still needed after start, for load extract
  typedef struct packed {
    logic       we;
    logic [2:0] f3;
    logic [1:0] a;
  } acc_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  acc_t        acc_q;
  logic        ma_q;
  logic [7:0]  cnt;
  logic        start, illegal, misal, bad, expire;
  logic [3:0]  strb_nx;
  logic [31:0] wd_nx, rd_sh, ld_val;

  assign start   = CLK_MA & ~ma_q & rwmem & (state == IDLE);
  assign illegal = we ? (funct3[2] | (funct3 == 3'b011))
                      : ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111));
  assign misal   = ((funct3[1:0] == 2'b01) & addr[0]) |
                   ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign bad     = illegal | misal;
  assign expire  = (state == REQ) & ~mem_ack & (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bad ? ERR : REQ;
      REQ:     if (mem_ack) state_nx = DONE;
               else if (cnt == CNT_LAST) state_nx = ERR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    strb_nx = 4'b0000;
    wd_nx   = 32'h0;
    if (we) begin
      case (funct3[1:0])
        2'b00:   begin wd_nx = {4{wdata[7:0]}};  strb_nx = 4'b0001 << addr[1:0]; end
        2'b01:   begin wd_nx = {2{wdata[15:0]}}; strb_nx = addr[1] ? 4'b1100 : 4'b0011; end
        default: begin wd_nx = wdata;            strb_nx = 4'b1111; end
      endcase
    end
  end

  assign rd_sh = mem_rdata >> {acc_q.a, 3'b000};
  always_comb begin
    ld_val = mem_rdata;
    case (acc_q.f3)
      3'b000:  ld_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_val = acc_q.a[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                   : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ld_val = {24'h0, rd_sh[7:0]};
      3'b101:  ld_val = acc_q.a[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      ma_q         <= 1'b0;
      cnt          <= 8'h0;
      acc_q        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wstrb    <= 4'h0;
      mem_wdata    <= 32'h0;
      rdata        <= 32'h0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state <= state_nx;
      ma_q  <= CLK_MA;
      cnt   <= (state == REQ) ? cnt + 8'h1 : 8'h0;
      if (start && !bad) begin
        acc_q     <= '{we: we, f3: funct3, a: addr[1:0]};
        mem_we    <= we;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wstrb <= strb_nx;
        mem_wdata <= wd_nx;
      end
      if (state == REQ && mem_ack && !acc_q.we) rdata <= ld_val;
      if (start && bad) err_misalign <= 1'b1;
      if (expire) err_timeout <= 1'b1;
    end
  end

  // bus request and stall are the same window: every REQ cycle
  assign mem_req     = (state == REQ);
  assign memWait     = (state == REQ);
  assign rdata_valid = (state == DONE) & ~acc_q.we;

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Memory-access stage responder. It is the far end of the stage-clock handshake: it watches the CLK_MA phase strobe and generates memWait back to the stage clock generator, so the stage counter stalls until the data-bus transaction finishes.
- Converts an RV32 load/store request (address, funct3, store data) into a word-aligned bus transaction with byte strobes.
- Returns the aligned, sign/zero-extended load data to the write-back stage.

Parameters:
- TIMEOUT, 255, bus cycles to wait for mem_ack before aborting with err_timeout (8-bit counter; legal range 1..255).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- CLK_MA  in  1  memory-access phase strobe from the stage clock generator
- rwmem  in  1  current instruction needs a memory access
- we  in  1  1=store, 0=load
- funct3  in  3  RV32 size/sign code
- addr  in  32  byte address
- wdata  in  32  store data (right-justified)
- mem_req  out  1  bus request; held until acknowledged
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wstrb  out  4  byte-lane strobes (0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion, single-cycle pulse
- mem_rdata  in  32  bus read word, valid with mem_ack
- memWait  out  1  stall to the stage clock generator
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle pulse when rdata updates
- err_misalign  out  1  sticky misaligned/illegal access flag
- err_timeout  out  1  sticky bus timeout flag

Behaviour:
- Reset:
  - All outputs reset to 0.
  - State returns to IDLE; the timeout counter and the CLK_MA edge register clear.
  - Reset during REQ drops mem_req the next cycle. A late mem_ack after that is ignored.
- Start detection:
  - ma_q is CLK_MA registered on CLK.
  - start = CLK_MA & ~ma_q & rwmem, evaluated only in IDLE.
  - Rising CLK_MA edges in any other state are ignored.
- States: IDLE, REQ, DONE, ERR.
- IDLE + start, legal access:
  - Next state REQ.
  - Next cycle: memWait=1, mem_req=1.
  - mem_addr, mem_we, mem_wstrb and mem_wdata are registered at start and stay stable throughout REQ.
- IDLE + start, illegal or misaligned access:
  - Next state ERR; no bus request is issued.
  - Illegal: loads with funct3 in {011,110,111}; stores with funct3 in {011,1xx}.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- REQ:
  - The counter increments each cycle.
  - On mem_ack: capture rdata (loads only), deassert mem_req, go to DONE.
  - If the counter reaches TIMEOUT without mem_ack: set err_timeout, go to ERR.
  - If mem_ack arrives in the same cycle as expiry, the ack wins.
- DONE (one cycle):
  - memWait=0.
  - rdata_valid=1 for loads only.
  - Next state IDLE.
- ERR (one cycle):
  - memWait=0; set err_misalign when the cause was misaligned or illegal.
  - rdata is unchanged; next state IDLE.
  - Error flags are sticky until RST.
- memWait latency:
  - memWait rises exactly 1 cycle after start.
  - For a bus ack on cycle k of REQ (k=1 is the first REQ cycle), memWait is high for k cycles.
- Store lanes, with a = addr[1:0]:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_wstrb=4'b0001<<a.
  - SH: mem_wdata={2{wdata[15:0]}}, mem_wstrb = 0011 when a=0, 1100 when a=2.
  - SW: mem_wdata=wdata, mem_wstrb=1111.
- Load extract:
  - LB/LBU: byte at lane a.
  - LH/LHU: halfword at lane a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rwmem=0 at a CLK_MA edge: no action, memWait stays 0.

Test Plan:
- LW addr=0x100, mem_ack on 3rd REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, memWait high 3 cycles, rdata=0xDEADBEEF, rdata_valid one pulse.
- LB addr=0x103 with mem_rdata=0x80112233 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011.
- SB addr=0x201 wdata=0x000000A5 -> mem_we=1, mem_addr=0x200, mem_wstrb=0010, mem_wdata=0xA5A5A5A5; SH addr=0x202 wdata=0x1234 -> wstrb=1100, wdata=0x12341234.
- LW addr=0x102 -> no mem_req, err_misalign=1, memWait never asserts; store funct3=100 -> err_misalign=1.
- TIMEOUT=4, no mem_ack -> mem_req high 4 cycles, err_timeout=1, memWait drops. Repeat with mem_ack on the 4th cycle -> DONE, err_timeout=0.
- RST asserted in the 2nd REQ cycle -> mem_req and memWait are 0 the next cycle; a later mem_ack is ignored; a second CLK_MA edge during REQ does not restart the access.
